// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared width default and alarm FSM state type
package counter_pkg;

    localparam int W_DEFAULT = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } alarm_state_t;

endpackage

// File: rtl/ts_fifo.sv
// rtl/ts_fifo.sv - synchronous timestamp FIFO, W x DEPTH
//  clk/rst       : clock, synchronous active-high reset (flushes pointers)
//  push/din      : write request and data; ignored when full unless popping
//  pop           : read request; ignored when empty
//  dout          : head entry, forced to 0 while empty
//  full/empty    : occupancy flags
module ts_fifo
    import counter_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/counter_alarm.sv
// rtl/counter_alarm.sv - compare alarm and event timestamp capture on the COUNTER timebase
//  CLOCK, RST                      : clock, synchronous active-high reset
//  COUNTER                         : free-running timebase input
//  CFG_VALID/CFG_READY             : config handshake; CFG_DISARM, CFG_CMP, CFG_PERIOD payload
//  ARMED, ALARM, LATE              : alarm state, one-cycle alarm pulse, late qualifier
//  EVT                             : event level, rising edge timestamped
//  TS_VALID/TS_READY/TS_DATA       : timestamp FIFO drain port
//  TS_DROP                         : one-cycle pulse when a capture is lost to a full FIFO
module counter_alarm
    import counter_pkg::*;
#(
    parameter int W          = W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         CLOCK,
    input  logic         RST,
    input  logic [W-1:0] COUNTER,
    input  logic         CFG_VALID,
    output logic         CFG_READY,
    input  logic         CFG_DISARM,
    input  logic [W-1:0] CFG_CMP,
    input  logic [W-1:0] CFG_PERIOD,
    output logic         ARMED,
    output logic         ALARM,
    output logic         LATE,
    input  logic         EVT,
    output logic         TS_VALID,
    input  logic         TS_READY,
    output logic [W-1:0] TS_DATA,
    output logic         TS_DROP
);

    alarm_state_t state;
    logic [W-1:0] cmp;
    logic [W-1:0] per;
    logic [W-1:0] diff;
    logic         cfg_fire;
    logic         due;

    logic         evt_q;
    logic         rise;
    logic         ts_pop;
    logic         fifo_full;
    logic         fifo_empty;

    assign cfg_fire = CFG_VALID && CFG_READY;
    assign ARMED    = (state == ST_ARMED);

    // Modular distance to the compare point: a clear MSB means COUNTER is at
    // or past CMP within half the counter range, which keeps the test wrap-safe.
    assign diff = COUNTER - cmp;
    assign due  = ARMED && !diff[W-1];

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            CFG_READY <= 1'b0;
        end else begin
            CFG_READY <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state <= ST_IDLE;
            cmp   <= '0;
            per   <= '0;
            ALARM <= 1'b0;
            LATE  <= 1'b0;
        end else begin
            ALARM <= 1'b0;
            LATE  <= 1'b0;
            // A new configuration overrides any alarm due in the same cycle.
            if (cfg_fire) begin
                if (CFG_DISARM) begin
                    state <= ST_IDLE;
                end else begin
                    cmp   <= CFG_CMP;
                    per   <= CFG_PERIOD;
                    state <= ST_ARMED;
                end
            end else if (due) begin
                ALARM <= 1'b1;
                LATE  <= (diff != '0);
                if (per == '0) begin
                    state <= ST_IDLE;
                end else begin
                    // Advancing by one period per cycle gives the catch-up
                    // burst when the compare time fell far behind COUNTER.
                    cmp <= cmp + per;
                end
            end
        end
    end

    // evt_q resets high so a level already asserted at reset release is not an edge.
    assign rise   = EVT && !evt_q;
    assign ts_pop = TS_VALID && TS_READY;

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            evt_q   <= 1'b1;
            TS_DROP <= 1'b0;
        end else begin
            evt_q   <= EVT;
            TS_DROP <= rise && fifo_full && !ts_pop;
        end
    end

    ts_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_ts_fifo (
        .clk   (CLOCK),
        .rst   (RST),
        .push  (rise),
        .din   (COUNTER),
        .pop   (ts_pop),
        .dout  (TS_DATA),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign TS_VALID = !fifo_empty;

endmodule

// File: tb/tb_counter_alarm.sv
// tb/tb_counter_alarm.sv - directed self-checking bench for counter_alarm
module tb_counter_alarm;

    localparam int W = 32;

    logic         CLOCK = 1'b0;
    logic         RST;
    logic [W-1:0] COUNTER;
    logic         CFG_VALID;
    logic         CFG_READY;
    logic         CFG_DISARM;
    logic [W-1:0] CFG_CMP;
    logic [W-1:0] CFG_PERIOD;
    logic         ARMED;
    logic         ALARM;
    logic         LATE;
    logic         EVT;
    logic         TS_VALID;
    logic         TS_READY;
    logic [W-1:0] TS_DATA;
    logic         TS_DROP;

    int vectors     = 0;
    int miscompares = 0;

    counter_alarm #(
        .W          (W),
        .FIFO_DEPTH (4)
    ) dut (
        .CLOCK      (CLOCK),
        .RST        (RST),
        .COUNTER    (COUNTER),
        .CFG_VALID  (CFG_VALID),
        .CFG_READY  (CFG_READY),
        .CFG_DISARM (CFG_DISARM),
        .CFG_CMP    (CFG_CMP),
        .CFG_PERIOD (CFG_PERIOD),
        .ARMED      (ARMED),
        .ALARM      (ALARM),
        .LATE       (LATE),
        .EVT        (EVT),
        .TS_VALID   (TS_VALID),
        .TS_READY   (TS_READY),
        .TS_DATA    (TS_DATA),
        .TS_DROP    (TS_DROP)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic dis, input logic [31:0] cmp, input logic [31:0] per);
        CFG_VALID  = 1'b1;
        CFG_DISARM = dis;
        CFG_CMP    = cmp;
        CFG_PERIOD = per;
        tick();
        CFG_VALID  = 1'b0;
        CFG_DISARM = 1'b0;
    endtask

    task automatic evt_pulse(input logic [31:0] stamp, input logic exp_drop);
        COUNTER = stamp;
        EVT     = 1'b1;
        tick();
        chk($sformatf("drop_on_%0d", stamp), 32'(TS_DROP), 32'(exp_drop));
        EVT = 1'b0;
        tick();
        chk($sformatf("drop_clear_%0d", stamp), 32'(TS_DROP), 32'd0);
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] exp_q [4];

        RST        = 1'b1;
        COUNTER    = '0;
        CFG_VALID  = 1'b0;
        CFG_DISARM = 1'b0;
        CFG_CMP    = '0;
        CFG_PERIOD = '0;
        EVT        = 1'b1;
        TS_READY   = 1'b0;
        tick();
        tick();

        chk("rst_armed",     32'(ARMED),     32'd0);
        chk("rst_alarm",     32'(ALARM),     32'd0);
        chk("rst_late",      32'(LATE),      32'd0);
        chk("rst_ts_valid",  32'(TS_VALID),  32'd0);
        chk("rst_ts_drop",   32'(TS_DROP),   32'd0);
        chk("rst_ts_data",   TS_DATA,        32'd0);
        chk("rst_cfg_ready", 32'(CFG_READY), 32'd0);

        // EVT held high through reset release must not be captured.
        RST = 1'b0;
        tick();
        chk("post_rst_cfg_ready", 32'(CFG_READY), 32'd1);
        tick();
        chk("evt_high_at_release", 32'(TS_VALID), 32'd0);
        EVT = 1'b0;
        tick();

        // One-shot at 100.
        COUNTER = 32'd90;
        cfg(1'b0, 32'd100, 32'd0);
        chk("t1_armed", 32'(ARMED), 32'd1);
        for (int i = 91; i <= 103; i++) begin
            COUNTER = 32'(i);
            tick();
            chk($sformatf("t1_alarm_c%0d", i), 32'(ALARM), 32'(i == 100));
            chk($sformatf("t1_armed_c%0d", i), 32'(ARMED), 32'(i < 100));
            chk($sformatf("t1_late_c%0d", i),  32'(LATE),  32'd0);
        end

        // Periodic 50/10, disarmed at 75.
        COUNTER = 32'd40;
        cfg(1'b0, 32'd50, 32'd10);
        for (int i = 41; i <= 80; i++) begin
            COUNTER = 32'(i);
            if (i == 75) begin
                CFG_VALID  = 1'b1;
                CFG_DISARM = 1'b1;
            end
            tick();
            CFG_VALID  = 1'b0;
            CFG_DISARM = 1'b0;
            chk($sformatf("t2_alarm_c%0d", i), 32'(ALARM), 32'(i == 50 || i == 60 || i == 70));
            chk($sformatf("t2_armed_c%0d", i), 32'(ARMED), 32'(i < 75));
        end

        // Wrap through zero.
        COUNTER = 32'hFFFF_FFFA;
        cfg(1'b0, 32'hFFFF_FFFE, 32'd4);
        c = 32'hFFFF_FFFB;
        for (int i = 0; i < 11; i++) begin
            COUNTER = c;
            tick();
            chk($sformatf("t3_alarm_c%0h", c), 32'(ALARM),
                32'(c == 32'hFFFF_FFFE || c == 32'd2));
            chk($sformatf("t3_late_c%0h", c), 32'(LATE), 32'd0);
            c = c + 32'd1;
        end
        cfg(1'b1, 32'd0, 32'd0);
        chk("t3_disarmed", 32'(ARMED), 32'd0);

        // Late arm: catch-up burst at COUNTER=200 for CMP 190,194,198.
        COUNTER = 32'd200;
        cfg(1'b0, 32'd190, 32'd4);
        chk("t4_armed",      32'(ARMED), 32'd1);
        chk("t4_arm_alarm0", 32'(ALARM), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4_burst_alarm%0d", i), 32'(ALARM), 32'd1);
            chk($sformatf("t4_burst_late%0d", i),  32'(LATE),  32'd1);
        end
        tick();
        chk("t4_burst_end", 32'(ALARM), 32'd0);
        COUNTER = 32'd201;
        tick();
        chk("t4_c201_alarm", 32'(ALARM), 32'd0);
        COUNTER = 32'd202;
        tick();
        chk("t4_c202_alarm", 32'(ALARM), 32'd1);
        chk("t4_c202_late",  32'(LATE),  32'd0);

        // Config in a due cycle (CMP now 206) wins over the old compare.
        COUNTER = 32'd206;
        cfg(1'b0, 32'd300, 32'd0);
        chk("cfg_wins_alarm", 32'(ALARM), 32'd0);
        chk("cfg_wins_armed", 32'(ARMED), 32'd1);
        cfg(1'b1, 32'd0, 32'd0);
        chk("t4_disarmed", 32'(ARMED), 32'd0);

        // FIFO fill, overflow, full+rise+pop, drain.
        evt_pulse(32'd1000, 1'b0);
        chk("t5_valid_first", 32'(TS_VALID), 32'd1);
        chk("t5_head_first",  TS_DATA,       32'd1000);
        evt_pulse(32'd1010, 1'b0);
        evt_pulse(32'd1020, 1'b0);
        evt_pulse(32'd1030, 1'b0);
        evt_pulse(32'd1040, 1'b1);
        chk("t5_head_after_drop", TS_DATA, 32'd1000);

        COUNTER  = 32'd1050;
        EVT      = 1'b1;
        TS_READY = 1'b1;
        tick();
        chk("t5_full_rise_pop_drop", 32'(TS_DROP), 32'd0);
        EVT      = 1'b0;
        TS_READY = 1'b0;
        tick();
        chk("t5_no_drop_late", 32'(TS_DROP), 32'd0);

        exp_q[0] = 32'd1010;
        exp_q[1] = 32'd1020;
        exp_q[2] = 32'd1030;
        exp_q[3] = 32'd1050;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_drain_valid%0d", i), 32'(TS_VALID), 32'd1);
            chk($sformatf("t5_drain_data%0d", i),  TS_DATA,       exp_q[i]);
            TS_READY = 1'b1;
            tick();
            TS_READY = 1'b0;
        end
        chk("t5_empty_valid", 32'(TS_VALID), 32'd0);
        chk("t5_empty_data",  TS_DATA,       32'd0);

        // Reset in the middle of a drain with the alarm armed.
        evt_pulse(32'd2000, 1'b0);
        evt_pulse(32'd2010, 1'b0);
        cfg(1'b0, 32'd5000, 32'd0);
        chk("t6_pre_armed", 32'(ARMED),    32'd1);
        chk("t6_pre_valid", 32'(TS_VALID), 32'd1);
        TS_READY = 1'b1;
        RST      = 1'b1;
        tick();
        chk("t6_rst_valid",     32'(TS_VALID),  32'd0);
        chk("t6_rst_armed",     32'(ARMED),     32'd0);
        chk("t6_rst_data",      TS_DATA,        32'd0);
        chk("t6_rst_cfg_ready", 32'(CFG_READY), 32'd0);
        RST      = 1'b0;
        TS_READY = 1'b0;
        tick();
        chk("t6_after_valid",     32'(TS_VALID),  32'd0);
        chk("t6_after_cfg_ready", 32'(CFG_READY), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
